// File: rtl/fetch_control.sv
// fetch_control: fetch-stage sequencer with halt detection, pipeline drain and
// saturating run/fetch cycle counters.
module fetch_control #(
  parameter logic [4:0] HALT_OP      = 5'b11111,
  parameter int         DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [16:0] instr_d,
  output logic        pc_en,
  output logic        pc_clear,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        running,
  output logic        halted,
  output logic [15:0] cycle_count,
  output logic [15:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
  state_t      state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic [15:0] cycle_q, cycle_d, fetch_q, fetch_d;
  logic        halt_det, accept;
  // a redirect or stall in the same cycle masks the halt opcode
  assign halt_det = state_q == RUN && instr_d[16:12] == HALT_OP && !branch_taken && !stall_req;
  assign accept   = (state_q == IDLE || state_q == HALTED) && start;
  assign cycle_count = cycle_q;
  assign fetch_count = fetch_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      cycle_q <= '0;
      fetch_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
      fetch_q <= fetch_d;
    end
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE, HALTED: state_d = start ? RUN : state_q;
      RUN: begin
        state_d = halt_det ? DRAIN : RUN;
        drain_d = halt_det ? DRAIN_LOAD : drain_q;
      end
      default: begin
        state_d = drain_q == '0 ? HALTED : DRAIN;
        drain_d = drain_q == '0 ? '0 : drain_q - 3'd1;
      end
    endcase
    cycle_d = accept ? '0 : (running && cycle_q != 16'hFFFF) ? cycle_q + 16'd1 : cycle_q;
    fetch_d = accept ? '0 : (pc_en && fetch_q != 16'hFFFF) ? fetch_q + 16'd1 : fetch_q;
  end
  always_comb begin
    running  = state_q == RUN;
    halted   = state_q == HALTED;
    pc_clear = accept;
    pc_en    = running && (branch_taken || (!stall_req && !halt_det));
    fd_en    = pc_en;
    fd_flush = !running || branch_taken || halt_det;
    de_flush = !running || branch_taken || stall_req;
  end
endmodule
